// File: rtl/eon_isa.sv
// Shared ISA definitions for the instruction assembly and pre-decode path.
package eon_isa;

  // Location of the length field in the first halfword of an instruction.
  localparam int LEN_MSB = 15;
  localparam int LEN_LSB = 14;

  // Length-field codes; any other code means a one-halfword instruction.
  localparam logic [1:0] LEN2 = 2'b10;
  localparam logic [1:0] LEN3 = 2'b11;

  // Reserved first halfword; always decoded as a one-halfword illegal op.
  localparam logic [15:0] ILLEGAL_WORD = 16'hFFFF;

  // Assembly progress of the decode stage.
  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,  // waiting for a first halfword
    ST_EXT1  = 2'd1,  // waiting for the second halfword
    ST_EXT2  = 2'd2,  // waiting for the third halfword
    ST_HOLD  = 2'd3   // complete instruction presented to execute
  } dec_state_e;

endpackage

// File: rtl/ilen_decode.sv
// Length/illegal decode of a first halfword. Pure combinational so that the
// predecoder and branch predictor can share it.
module ilen_decode
  import eon_isa::*;
(
  input  logic [15:0] word,
  output logic [1:0]  len,
  output logic        illegal
);

  // Classify the halfword; the illegal pattern overrides the length field.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    len     = 2'd1;
    illegal = 1'b0;
    if (word == ILLEGAL_WORD) begin
      illegal = 1'b1;
    end else begin
      case (word[LEN_MSB:LEN_LSB])
        LEN3:    len = 2'd3;
        LEN2:    len = 2'd2;
        default: len = 2'd1;
      endcase
    end
  end

endmodule

// File: rtl/idecode.sv
// Instruction assembly stage: collects 1-3 halfwords from fetch, tags the
// instruction with its pc and next pc, and holds it until execute takes it.
module idecode
  import eon_isa::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] flush_pc,
  input  logic [15:0]      word,
  input  logic             op_ready,
  output logic             d_ready,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [47:0]      ins_bits,
  output logic [1:0]       ins_len,
  output logic [WIDTH-1:0] ins_pc,
  output logic [WIDTH-1:0] ins_next_pc,
  output logic             ins_illegal
);

  dec_state_e       state;
  dec_state_e       state_nxt;
  logic [1:0]       dec_len;
  logic             dec_illegal;
  logic [WIDTH-1:0] cur_pc;
  logic             xfer;
  logic             load_first;

  ilen_decode u_ilen (
    .word    (word),
    .len     (dec_len),
    .illegal (dec_illegal)
  );

  // Handshake outputs; d_ready is combinational so HOLD can hand off and
  // accept a new first halfword in the same cycle.
  always_comb begin
    ins_valid = (state == ST_HOLD);
    d_ready   = !flush && ((state != ST_HOLD) || ins_ready);
  end

  assign xfer       = op_ready && d_ready;
  // A transfer in HOLD implies ins_ready, so it starts a new instruction.
  assign load_first = xfer && ((state == ST_FIRST) || (state == ST_HOLD));

  // Next-state logic; flush wins over everything else.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_FIRST;
    end else begin
      case (state)
        ST_FIRST, ST_HOLD: begin
          if (xfer) begin
            state_nxt = (dec_len == 2'd1) ? ST_HOLD : ST_EXT1;
          end else if (state == ST_HOLD && ins_ready) begin
            state_nxt = ST_FIRST;
          end
        end
        ST_EXT1: begin
          if (xfer) begin
            state_nxt = (ins_len == 2'd2) ? ST_HOLD : ST_EXT2;
          end
        end
        ST_EXT2: begin
          if (xfer) begin
            state_nxt = ST_HOLD;
          end
        end
        default: state_nxt = ST_FIRST;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= ST_FIRST;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch address tracker: follows every accepted halfword, reloads on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_pc <= '0;
    end else if (flush) begin
      cur_pc <= flush_pc;
    end else if (xfer) begin
      cur_pc <= cur_pc + WIDTH'(2);
    end
  end

  // Instruction register: first halfword sets the tags, extensions fill in.
  always_ff @(posedge clk) begin
    if (rst) begin
      ins_bits    <= '0;
      ins_len     <= 2'd1;
      ins_pc      <= '0;
      ins_next_pc <= WIDTH'(2);
      ins_illegal <= 1'b0;
    end else if (load_first) begin
      ins_bits    <= {word, 32'h0};
      ins_len     <= dec_len;
      ins_pc      <= cur_pc;
      ins_next_pc <= cur_pc + WIDTH'({dec_len, 1'b0});
      ins_illegal <= dec_illegal;
    end else if (xfer && state == ST_EXT1) begin
      ins_bits[31:16] <= word;
    end else if (xfer && state == ST_EXT2) begin
      ins_bits[15:0] <= word;
    end
  end

endmodule

// File: tb/tb_idecode.sv
// Bench for idecode: directed scenarios followed by random traffic, all
// checked cycle by cycle against a halfword-queue reference model.
module tb_idecode;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic [15:0] word;
  logic        op_ready;
  logic        d_ready;
  logic        ins_valid;
  logic        ins_ready;
  logic [47:0] ins_bits;
  logic [1:0]  ins_len;
  logic [31:0] ins_pc;
  logic [31:0] ins_next_pc;
  logic        ins_illegal;

  int total = 0;
  int bad   = 0;

  idecode #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .word        (word),
    .op_ready    (op_ready),
    .d_ready     (d_ready),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_bits    (ins_bits),
    .ins_len     (ins_len),
    .ins_pc      (ins_pc),
    .ins_next_pc (ins_next_pc),
    .ins_illegal (ins_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  len;
    logic [47:0] bits;
    logic [31:0] nxt;
    logic        ill;
  } ins_t;

  // Reference model: halfwords gathered so far, and the instruction on offer.
  logic [15:0] m_part[$];
  logic [31:0] m_pc;
  logic [31:0] m_start;
  logic        m_have;
  ins_t        m_exp;
  ins_t        log_q[$];   // instructions observed being consumed

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_len(input logic [15:0] w);
    if (w == 16'hFFFF) return 1;
    if (w[15:14] == 2'b11) return 3;
    if (w[15:14] == 2'b10) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    m_part.delete();
    m_pc    = 32'h0;
    m_start = 32'h0;
    m_have  = 1'b0;
  endtask

  // One clock: drive inputs, check against the model, advance the model.
  task automatic step(input logic f, input logic [31:0] fpc, input logic [15:0] w,
                      input logic opr, input logic insr);
    logic mdl_rdy;
    logic mdl_xfer;
    ins_t obs;
    flush = f; flush_pc = fpc; word = w; op_ready = opr; ins_ready = insr;
    #1;
    mdl_rdy  = !f && (!m_have || insr);
    mdl_xfer = opr && mdl_rdy;
    check("d_ready", d_ready, mdl_rdy);
    check("ins_valid", ins_valid, m_have);
    if (m_have) begin
      check("ins_pc", ins_pc, m_exp.pc);
      check("ins_len", ins_len, m_exp.len);
      check("ins_bits", ins_bits, m_exp.bits);
      check("ins_next_pc", ins_next_pc, m_exp.nxt);
      check("ins_illegal", ins_illegal, m_exp.ill);
    end
    if (ins_valid && insr && !f) begin
      obs.pc = ins_pc; obs.len = ins_len; obs.bits = ins_bits;
      obs.nxt = ins_next_pc; obs.ill = ins_illegal;
      log_q.push_back(obs);
    end
    @(posedge clk);
    if (f) begin
      m_part.delete();
      m_have = 1'b0;
      m_pc   = fpc;
    end else begin
      if (m_have && insr) m_have = 1'b0;
      if (mdl_xfer) begin
        if (m_part.size() == 0) m_start = m_pc;
        m_part.push_back(w);
        m_pc = m_pc + 32'd2;
        if (m_part.size() == exp_len(m_part[0])) begin
          m_exp.pc   = m_start;
          m_exp.len  = 2'(exp_len(m_part[0]));
          m_exp.bits = {m_part[0],
                        (m_part.size() > 1) ? m_part[1] : 16'h0,
                        (m_part.size() > 2) ? m_part[2] : 16'h0};
          m_exp.nxt  = m_start + 32'(2 * exp_len(m_part[0]));
          m_exp.ill  = (m_part[0] == 16'hFFFF);
          m_have = 1'b1;
          m_part.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; flush_pc = '0; word = '0; op_ready = 1'b0; ins_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", ins_valid, 1'b0);
    check("rst_bits", ins_bits, 48'h0);
    check("rst_len", ins_len, 2'd1);
    check("rst_pc", ins_pc, 32'h0);
    check("rst_next_pc", ins_next_pc, 32'h2);
    check("rst_illegal", ins_illegal, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] t1_words[6];
    int n0;
    t1_words = '{16'h1234, 16'h8001, 16'hABCD, 16'hC002, 16'h0003, 16'h0004};

    do_reset();

    // Back-to-back stream of 1-, 2- and 3-halfword instructions.
    foreach (t1_words[i]) step(1'b0, 32'h0, t1_words[i], 1'b1, 1'b1);
    step(1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
    check("t1_count", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      check("t1_i0_pc", log_q[0].pc, 32'h0);
      check("t1_i0_len", log_q[0].len, 2'd1);
      check("t1_i0_bits", log_q[0].bits, 48'h1234_0000_0000);
      check("t1_i1_pc", log_q[1].pc, 32'h2);
      check("t1_i1_len", log_q[1].len, 2'd2);
      check("t1_i1_bits", log_q[1].bits, 48'h8001_ABCD_0000);
      check("t1_i2_pc", log_q[2].pc, 32'h6);
      check("t1_i2_len", log_q[2].len, 2'd3);
      check("t1_i2_bits", log_q[2].bits, 48'hC002_0003_0004);
      check("t1_i2_next", log_q[2].nxt, 32'd12);
    end

    // Execute stalls with a len-1 instruction held; then releases.
    step(1'b0, 32'h0, 16'h0005, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 16'h0006, 1'b1, 1'b0);
      check("t2_stall_rdy", d_ready, 1'b0);
      check("t2_stall_bits", ins_bits, 48'h0005_0000_0000);
      check("t2_stall_pc", ins_pc, 32'd12);
    end
    n0 = log_q.size();
    step(1'b0, 32'h0, 16'h0006, 1'b1, 1'b1);
    check("t2_handoff_cnt", log_q.size(), n0 + 1);
    check("t2_new_valid", ins_valid, 1'b1);
    check("t2_new_pc", ins_pc, 32'd14);
    check("t2_new_bits", ins_bits, 48'h0006_0000_0000);
    step(1'b0, 32'h0, 16'h0, 1'b0, 1'b1);

    // Flush in the middle of a 3-halfword instruction.
    step(1'b0, 32'h0, 16'hC010, 1'b1, 1'b1);
    step(1'b0, 32'h0, 16'h0011, 1'b1, 1'b1);
    step(1'b1, 32'h100, 16'h7777, 1'b1, 1'b1);
    step(1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
    check("t3_no_valid", ins_valid, 1'b0);
    step(1'b0, 32'h0, 16'h0042, 1'b1, 1'b1);
    check("t3_valid", ins_valid, 1'b1);
    check("t3_pc", ins_pc, 32'h100);
    check("t3_len", ins_len, 2'd1);
    check("t3_bits", ins_bits, 48'h0042_0000_0000);

    // Flush, ins_ready and op_ready together while holding.
    n0 = log_q.size();
    step(1'b1, 32'h200, 16'h1111, 1'b1, 1'b1);
    check("t4_dropped", log_q.size(), n0);
    check("t4_no_valid", ins_valid, 1'b0);
    step(1'b0, 32'h0, 16'h8123, 1'b1, 1'b1);
    step(1'b0, 32'h0, 16'h4444, 1'b1, 1'b1);
    check("t4_pc", ins_pc, 32'h200);
    check("t4_bits", ins_bits, 48'h8123_4444_0000);

    // Illegal halfword, then its near neighbour which is a legal len-3 op.
    step(1'b0, 32'h0, 16'hFFFF, 1'b1, 1'b1);
    check("t5_illegal", ins_illegal, 1'b1);
    check("t5_ill_len", ins_len, 2'd1);
    step(1'b0, 32'h0, 16'hFFFE, 1'b1, 1'b1);
    step(1'b0, 32'h0, 16'h0001, 1'b1, 1'b1);
    step(1'b0, 32'h0, 16'h0002, 1'b1, 1'b1);
    check("t5_legal", ins_illegal, 1'b0);
    check("t5_len3", ins_len, 2'd3);

    // Address wrap across the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 16'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 16'hC000, 1'b1, 1'b1);
    step(1'b0, 32'h0, 16'h0001, 1'b1, 1'b1);
    step(1'b0, 32'h0, 16'h0002, 1'b1, 1'b1);
    check("t6_pc", ins_pc, 32'hFFFF_FFFC);
    check("t6_next_pc", ins_next_pc, 32'h0000_0002);
    check("t6_len", ins_len, 2'd3);
    step(1'b0, 32'h0, 16'h0, 1'b0, 1'b1);

    // Reset in mid-assembly discards the partial instruction.
    step(1'b0, 32'h0, 16'hC123, 1'b1, 1'b1);
    do_reset();
    step(1'b0, 32'h0, 16'h0077, 1'b1, 1'b1);
    check("rst_mid_pc", ins_pc, 32'h0);
    check("rst_mid_bits", ins_bits, 48'h0077_0000_0000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           32'($urandom()),
           16'($urandom()),
           ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idecode.md
Name: idecode

Overview:
- Instruction assembly and pre-decode stage, directly downstream of the fetch stage.
- Consumes the 16-bit halfword stream from fetch using the op_ready/d_ready handshake.
- Assembles variable-length instructions of 1, 2 or 3 halfwords and tags each with its pc and next pc.
- Presents one instruction at a time to execute through a valid/ready handshake. Discards partial state on a pc load.

Parameters:
WIDTH, 32, address width; must match the fetch stage.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
flush  input  1  pc load from execute; same signal that drives fetch pcload
flush_pc  input  WIDTH  new pc on flush; same value as fetch pcin
word  input  16  halfword from fetch
op_ready  input  1  word is valid
d_ready  output  1  stage accepts word this cycle; drives fetch d_ready
ins_valid  output  1  assembled instruction available
ins_ready  input  1  execute consumes instruction
ins_bits  output  48  instruction; first halfword in [47:32], second in [31:16], third in [15:0]; unused halfwords are zero
ins_len  output  2  length in halfwords: 1, 2 or 3
ins_pc  output  WIDTH  address of the first halfword
ins_next_pc  output  WIDTH  ins_pc + 2*ins_len, modulo 2^WIDTH
ins_illegal  output  1  first halfword is 16'hFFFF

Behaviour:
- Transfer: a word transfers when op_ready & d_ready in the same cycle.
- d_ready = !flush && (state != HOLD || ins_ready). This is combinational, so a back-to-back consume and accept costs no bubble.
- Length decode of the first halfword w:
  - w == 16'hFFFF: len 1, illegal = 1.
  - w[15:14] == 2'b11: len 3.
  - w[15:14] == 2'b10: len 2.
  - otherwise: len 1.
- Internal fetch address cur_pc:
  - Reset value 0, matching fetch reset.
  - Increments by 2 on every transfer, wrapping modulo 2^WIDTH.
  - On flush, cur_pc <= flush_pc.
- States: FIRST (expect first halfword), EXT1, EXT2, HOLD.
  - FIRST + transfer: latch w into [47:32], zero [31:0], latch pc and len. Go to HOLD if len 1, otherwise EXT1.
  - EXT1 + transfer: latch into [31:16]. Go to HOLD if len 2, otherwise EXT2.
  - EXT2 + transfer: latch into [15:0]. Go to HOLD.
  - HOLD: ins_valid = 1; all ins_* outputs stay stable until ins_ready.
  - HOLD + ins_ready without transfer: go to FIRST.
  - HOLD + ins_ready + transfer: the word is a new first halfword; same handling as FIRST + transfer.
  - No transfer in FIRST/EXT1/EXT2: hold state; a partial instruction waits indefinitely.
- Latency: ins_valid rises the cycle after the last halfword transfers.
- ins_next_pc is registered at the first-halfword transfer.
- Flush:
  - Highest priority, over ins_ready and transfer in the same cycle.
  - Next state is FIRST, ins_valid = 0, any partial instruction is discarded.
  - d_ready is 0 during the flush cycle, so no word is accepted.
- Reset values: state FIRST, ins_valid 0, ins_bits 0, ins_len 1, ins_pc 0, ins_next_pc 2, ins_illegal 0, cur_pc 0. Reset in mid-assembly discards everything.
- ins_illegal travels with its instruction and causes no special stall.

Decomposition:
- Shared package eon_isa:
  - length field position [15:14] and codes LEN2 = 2'b10, LEN3 = 2'b11;
  - ILLEGAL_WORD = 16'hFFFF;
  - decode state enum.
- One combinational sub-module ilen_decode: word in, len[1:0] and illegal out. It will be reused by the future predecoder/branch predictor.

Test Plan:
1. Reset, then words 16'h1234, 16'h8001, 16'hABCD, 16'hC002, 16'h0003, 16'h0004 with op_ready held high and ins_ready high -> three instructions:
   - pc 0, len 1, bits 0x1234_0000_0000;
   - pc 2, len 2, bits 0x8001_ABCD_0000;
   - pc 6, len 3, bits 0xC002_0003_0004, next_pc 12.
2. ins_ready held low for 5 cycles with a len-1 instruction in HOLD -> d_ready 0 and outputs unchanged. ins_ready rising with op_ready high -> next word accepted in that same cycle.
3. Flush with flush_pc 0x100 after the second halfword of a len-3 instruction -> partial discarded, no ins_valid. The next word 16'h0042 emits pc 0x100, len 1.
4. Flush, ins_ready and op_ready in the same cycle while in HOLD -> instruction dropped, word not accepted, state FIRST.
5. First word 16'hFFFF -> ins_illegal 1, len 1. A following word 16'hFFFE -> len 3, illegal 0.
6. flush_pc 0xFFFF_FFFC followed by a len-3 instruction -> ins_pc 0xFFFF_FFFC, ins_next_pc 0x0000_0002.
